// File: rtl/lif_pkg.sv
// Shared types and sizing helpers for the neuron tile load streamer.
// Holds the state enum, the byte-count function and counter widths.
package lif_pkg;

  localparam int N_STAGES_DEF = 5;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  // Bytes per vector: a vector narrower than a byte still takes one.
  function automatic int lif_bytes(input int n_stages);
    int inputs;
    inputs = 1 << n_stages;
    return (inputs >= 8) ? inputs / 8 : 1;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width of the run-window counter, $clog2(MIN_RUN_CYCLES+1) min 1.
  function automatic int run_cnt_w(input int min_run);
    return (min_run < 1) ? 1 : $clog2(min_run + 1);
  endfunction

endpackage

// File: rtl/lif_byte_serializer.sv
// Parallel-load shift register that presents its MS byte first.
// Ports: clk, reset, load, shift, data_in[W], byte_out[8], last.
module lif_byte_serializer
  import lif_pkg::*;
#(
  parameter int W     = 32,
  parameter int BYTES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] data_in,
  output logic [7:0]   byte_out,
  output logic         last
);

  localparam int CW = cnt_w(BYTES);

  logic [W-1:0]  sr;
  logic [W-1:0]  sr_shl;
  logic [CW-1:0] cnt;

  // Shifting past the final byte leaves zeros, so the bus idles at 0.
  generate
    if (W > 8) begin : g_wide
      assign sr_shl   = {sr[W-9:0], 8'h00};
      assign byte_out = sr[W-1 -: 8];
    end else if (W == 8) begin : g_byte
      assign sr_shl   = '0;
      assign byte_out = sr;
    end else begin : g_narrow
      assign sr_shl   = '0;
      assign byte_out = {{(8-W){1'b0}}, sr};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= data_in;
      cnt <= CW'(BYTES - 1);
    end else if (shift) begin
      sr <= sr_shl;
      if (cnt != '0) cnt <= cnt - CW'(1);
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/lif_load_streamer.sv
// Host-side byte-serial loader for the LIF/PWM neuron tile.
// Ports: load_valid/ready/weights/data in; data_out, sel_weights, mode_run, busy, done out.
module lif_load_streamer
  import lif_pkg::*;
#(
  parameter  int N_STAGES       = N_STAGES_DEF,
  parameter  int MIN_RUN_CYCLES = 1,
  localparam int INPUTS         = 2 ** N_STAGES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic              load_weights,
  input  logic [INPUTS-1:0] load_data,
  output logic [7:0]        data_out,
  output logic              sel_weights,
  output logic              mode_run,
  output logic              busy,
  output logic              done
);

  localparam int BYTES = lif_bytes(N_STAGES);
  localparam int RW    = run_cnt_w(MIN_RUN_CYCLES);

  state_t        state, state_n;
  logic [RW-1:0] run_cnt, run_cnt_n;
  logic          sel_n, mode_n, busy_n, done_n, ready_n;
  logic          hs;
  logic          ser_last;

  assign hs = load_valid && load_ready;

  // data_out comes straight off the shift register flops.
  lif_byte_serializer #(
    .W     (INPUTS),
    .BYTES (BYTES)
  ) u_ser (
    .clk      (clk),
    .reset    (reset),
    .load     (hs),
    .shift    (state == SEND),
    .data_in  (load_data),
    .byte_out (data_out),
    .last     (ser_last)
  );

  always_comb begin
    state_n   = state;
    run_cnt_n = run_cnt;
    sel_n     = sel_weights;
    done_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (hs) begin
          state_n = SEND;
          sel_n   = load_weights;
        end
      end
      SEND: begin
        if (ser_last) begin
          done_n = 1'b1;
          if (MIN_RUN_CYCLES > 0) begin
            state_n   = GAP;
            run_cnt_n = RW'(MIN_RUN_CYCLES - 1);
          end else begin
            state_n = IDLE;
          end
        end
      end
      GAP: begin
        if (run_cnt == '0) state_n = IDLE;
        else run_cnt_n = run_cnt - RW'(1);
      end
      default: state_n = IDLE;
    endcase
    // Outputs follow the state being entered, so they are registered.
    mode_n  = (state_n != SEND);
    busy_n  = (state_n != IDLE);
    ready_n = (state_n == IDLE);
    if (state_n != SEND) sel_n = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      run_cnt     <= '0;
      sel_weights <= 1'b0;
      mode_run    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      load_ready  <= 1'b1;
    end else begin
      state       <= state_n;
      run_cnt     <= run_cnt_n;
      sel_weights <= sel_n;
      mode_run    <= mode_n;
      busy        <= busy_n;
      done        <= done_n;
      load_ready  <= ready_n;
    end
  end

endmodule

// File: doc/lif_load_streamer.md
Name: lif_load_streamer

Overview:
- Host-side transmitter for the neuron tile's byte-serial load interface.
- Accepts one full input vector or weight vector per valid/ready handshake. Emits it as a sequence of bytes on data_out, with select and mode pins driven exactly as the neuron top-level expects on ui_in / uio_in[1:0].
- Sits in front of the LIF/PWM neuron top, on the test harness or FPGA side. Returns the neuron to run mode after each load and enforces a minimum run window between loads.

Parameters:
- N_STAGES, 5, vector width is INPUTS = 2**N_STAGES; weight width equals INPUTS.
- MIN_RUN_CYCLES, 1, run-mode cycles forced after each load before load_ready reasserts; 0 allowed.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- load_valid  in  1  host has a vector to send
- load_ready  out  1  streamer can accept a vector
- load_weights  in  1  1 = vector is weights, 0 = inputs; sampled at handshake
- load_data  in  INPUTS  vector to send; sampled at handshake
- data_out  out  8  byte bus (drives neuron ui_in)
- sel_weights  out  1  drives uio_in[0]; 1 = weights
- mode_run  out  1  drives uio_in[1]; 0 = load mode (neuron shifts in data_out), 1 = run
- busy  out  1  high in SEND and GAP
- done  out  1  one-cycle pulse when the last byte has been presented

Behaviour:
- Derived constant: BYTES = INPUTS/8 when INPUTS >= 8, else 1.
- All outputs are registered.
- Reset values: state IDLE, data_out 0, sel_weights 0, mode_run 1, busy 0, done 0, load_ready 1, shift register 0, counters 0.

State IDLE:
- Outputs: load_ready = 1, mode_run = 1, data_out = 0, sel_weights = 0.
- Handshake when load_valid && load_ready at edge T.
- On handshake: latch load_data into the shift register, latch load_weights, load byte counter = BYTES-1, go to SEND.

State SEND (cycles T+1 .. T+BYTES):
- mode_run = 0; sel_weights = latched value; load_ready = 0.
- data_out = most-significant remaining byte, so the first byte presented is load_data[INPUTS-1 -: 8].
- Each cycle: shift left by 8 and decrement the counter.
- Byte order matches the receiver's shift-left-by-8 rule: after BYTES load-mode cycles, the receiver register equals load_data.
- INPUTS < 8: one byte, data_out = {zeros, load_data}.
- Exit after the last byte: go to GAP if MIN_RUN_CYCLES > 0, else IDLE.
- At T+BYTES+1: mode_run = 1, data_out = 0, sel_weights = 0, done = 1 for exactly that cycle.

State GAP:
- mode_run = 1; run counter counts MIN_RUN_CYCLES cycles, then go to IDLE.
- load_ready is high at T+BYTES+1+MIN_RUN_CYCLES.

Handshake and boundary rules:
- load_valid while busy: ignored, no queuing.
- load_data / load_weights changes after the handshake: no effect.
- Back-to-back handshakes are separated by at least BYTES+1+MIN_RUN_CYCLES cycles.
- mode_run is never low for more than BYTES consecutive cycles.
- sel_weights never changes while mode_run = 0.
- Reset mid-SEND or mid-GAP: next edge gives reset values (mode_run = 1, data 0). The partial load is abandoned; the neuron side shares the same reset.
- done and load_ready are never both high in the same cycle when MIN_RUN_CYCLES > 0.

Decomposition:
- Package lif_pkg:
  - N_STAGES default
  - function lif_bytes(n_stages) returning BYTES
  - state enum {IDLE, SEND, GAP}
  - RUN_CNT_W = $clog2(MIN_RUN_CYCLES+1) helper
- One sub-module, lif_byte_serializer:
  - parameterised parallel-load, MSB-byte-first shift register with byte counter
  - ports: load, shift, data_in, byte_out, last
- The FSM, GAP counter and handshake live in lif_load_streamer.

Test Plan:
1. N_STAGES=5, MIN_RUN_CYCLES=1; handshake at T with load_weights=1, load_data=32'hDEADBEEF -> at T+1..T+4 data_out = DE, AD, BE, EF, with mode_run=0 and sel_weights=1. At T+5: done=1, mode_run=1, data_out=0. At T+6: load_ready=1.
2. Same configuration with a behavioural copy of the receiver's shift rule attached; send inputs 32'h0000_00F1, then weights 32'hFFFF_0000 -> receiver inputs = 32'h000000F1 and weights = 32'hFFFF0000. mode_run is low for exactly 4 cycles per load.
3. load_valid held high continuously with changing load_data -> a handshake only every 6 cycles; each byte stream matches the data value present at its handshake.
4. Reset asserted at T+2 of a send -> at T+3: mode_run=1, data_out=0, sel_weights=0, busy=0, load_ready=1, no done pulse.
5. N_STAGES=2, MIN_RUN_CYCLES=0; handshake with load_data=4'hA -> at T+1 data_out=8'h0A with mode_run=0. At T+2: done=1, mode_run=1, load_ready=1.
6. MIN_RUN_CYCLES=3 -> after done, load_ready stays low for 3 cycles; a load_valid pulse inside that window is not accepted.
